ahb_ddr3_mem_tester: RTL and testbench

AHB_DDR3_MEM_TESTER -- requirements
Module: ahb_ddr3_mem_tester

---
 rtl/ahb_ddr3_mem_tester.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_ddr3_mem_tester.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ddr3_mem_tester.sv
// AHB-Lite memory tester: writes an index-derived pattern to NUM_WORDS 64-bit words,
// reads them back, counts mismatches and reports pass/fail or bus error.
module ahb_ddr3_mem_tester #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        START,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        BUS_ERR,
  output logic [15:0] ERR_CNT,
  output logic [31:0] FAIL_ADDR
);

  localparam int unsigned IDX_W = 16;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_A, ST_WR_D, ST_RD_A, ST_RD_D, ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        haddr_q, haddr_d;
  logic [1:0]         htrans_q, htrans_d;
  logic               hwrite_q, hwrite_d;
  logic [63:0]        hwdata_q, hwdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               bus_err_q, bus_err_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [31:0]        fail_addr_q, fail_addr_d;
  logic               finish;

  // Byte address of word idx, wrapping modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + {13'd0, idx, 3'd0};
  endfunction

  // Test pattern: inverted index in the upper half, index in the lower half.
  function automatic logic [63:0] pattern(input logic [IDX_W-1:0] idx);
    return {~{16'h0000, idx}, {16'h0000, idx}};
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    bus_err_d   = bus_err_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    finish      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d     = ST_WR_A;
          idx_d       = '0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          bus_err_d   = 1'b0;
          busy_d      = 1'b1;
          htrans_d    = HTRANS_NONSEQ;
          hwrite_d    = 1'b1;
          haddr_d     = word_addr('0);
        end
      end
      ST_WR_A: begin
        if (HREADY) begin
          state_d  = ST_WR_D;
          htrans_d = HTRANS_IDLE;
          hwdata_d = pattern(idx_q);
        end
      end
      ST_WR_D: begin
        if (HREADY) begin
          hwdata_d = '0;
          if (HRESP) begin
            bus_err_d = 1'b1;
            finish    = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d  = ST_RD_A;
            idx_d    = '0;
            haddr_d  = word_addr('0);
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b0;
          end else begin
            state_d  = ST_WR_A;
            idx_d    = idx_q + 16'd1;
            haddr_d  = word_addr(idx_q + 16'd1);
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
          end
        end
      end
      ST_RD_A: begin
        if (HREADY) begin
          state_d  = ST_RD_D;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_RD_D: begin
        if (HREADY) begin
          if (HRESP) begin
            bus_err_d = 1'b1;
            finish    = 1'b1;
          end else begin
            if (HRDATA != pattern(idx_q)) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
              if (err_cnt_q == 16'd0)    fail_addr_d = word_addr(idx_q);
            end
            if (idx_q == LAST_IDX) begin
              finish = 1'b1;
            end else begin
              state_d  = ST_RD_A;
              idx_d    = idx_q + 16'd1;
              haddr_d  = word_addr(idx_q + 16'd1);
              htrans_d = HTRANS_NONSEQ;
              hwrite_d = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d  = ST_DONE;
      htrans_d = HTRANS_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      pass_d   = (err_cnt_d == 16'd0) && !bus_err_d;
    end
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      bus_err_q   <= bus_err_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign BUS_ERR   = bus_err_q;
  assign ERR_CNT   = err_cnt_q;
  assign FAIL_ADDR = fail_addr_q;

endmodule

// File: tb/tb_ahb_ddr3_mem_tester.sv
// Scoreboard bench for ahb_ddr3_mem_tester with a small AHB memory slave model.
module tb_ahb_ddr3_mem_tester;

  localparam int NW = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] ADDR_T [4] = '{32'h00, 32'h08, 32'h10, 32'h18};
  localparam logic [63:0] PAT_T  [4] = '{64'hFFFFFFFF_00000000, 64'hFFFFFFFE_00000001,
                                         64'hFFFFFFFD_00000002, 64'hFFFFFFFC_00000003};

  logic        HCLK = 1'b0;
  logic        HRESETN, START, HREADY, HRESP, HWRITE;
  logic [63:0] HRDATA, HWDATA;
  logic [31:0] HADDR, FAIL_ADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic        BUSY, DONE, PASS, BUS_ERR;
  logic [15:0] ERR_CNT;

  ahb_ddr3_mem_tester #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .START(START), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRESP(HRESP), .HRDATA(HRDATA), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .BUS_ERR(BUS_ERR), .ERR_CNT(ERR_CNT), .FAIL_ADDR(FAIL_ADDR));

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Slave model: memory with configurable wait states per phase, error and corruption injection.
  logic [63:0] mem [16];
  logic        dphase, dwrite;
  logic [31:0] daddr;
  int          wcnt;
  int          ws = 0;
  logic        err_en = 1'b0, bad_en = 1'b0;
  logic [31:0] err_addr = '0, bad_addr = '0;

  assign HREADY = (wcnt >= ws);
  assign HRESP  = dphase && err_en && dwrite && (daddr == err_addr);

  always_comb begin
    HRDATA = '0;
    if (dphase && !dwrite) begin
      HRDATA = mem[daddr[6:3]];
      if (bad_en && daddr == bad_addr) HRDATA = HRDATA ^ 64'h1;
    end
  end

  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      dphase <= 1'b0; dwrite <= 1'b0; daddr <= '0; wcnt <= 0;
    end else if (!dphase && HTRANS != 2'b10) begin
      wcnt <= 0;
    end else if (HREADY) begin
      wcnt <= 0;
      if (dphase && dwrite && !HRESP) mem[daddr[6:3]] <= HWDATA;
      dphase <= (HTRANS == 2'b10);
      dwrite <= HWRITE;
      daddr  <= HADDR;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  typedef struct { logic wr; logic [31:0] addr; logic [63:0] data; } xfer_t;
  typedef struct { logic pass; logic be; logic [15:0] ec; logic [31:0] fa; int cyc; } res_t;
  xfer_t exp_x [$];
  res_t  exp_r [$];

  task automatic push_xfers(input logic wr, input int n);
    for (int i = 0; i < n; i++) exp_x.push_back('{wr, ADDR_T[i], PAT_T[i]});
  endtask

  task automatic push_res(input logic p, input logic be, input logic [15:0] ec,
                          input logic [31:0] fa, input int cyc);
    exp_r.push_back('{p, be, ec, fa, cyc});
  endtask

  // Monitor: checks address phases, write data, and run results against the queues.
  int    cyc = 0, busy_cyc = 0, done_seen = 0;
  logic  prev_done = 1'b0, prev_busy = 1'b0;
  xfer_t cur;

  always @(negedge HCLK) begin
    cyc++;
    if (HRESETN) begin
      if (HTRANS == 2'b10 && HREADY) begin
        if (exp_x.size() == 0) begin
          check("unexpected_xfer", {32'h0, HADDR}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          cur = exp_x.pop_front();
          check("haddr", {32'h0, HADDR}, {32'h0, cur.addr});
          check("hwrite", {63'h0, HWRITE}, {63'h0, cur.wr});
        end
      end
      if (dphase && dwrite) begin
        check("hwdata", HWDATA, cur.data);
        check("haddr_hold", {32'h0, HADDR}, {32'h0, cur.addr});
      end else begin
        check("hwdata_zero", HWDATA, 64'h0);
      end
      if (BUSY && !prev_busy) busy_cyc = cyc;
      if (DONE && !prev_done) begin
        done_seen++;
        if (exp_r.size() == 0) begin
          check("unexpected_done", 64'h1, 64'h0);
        end else begin
          res_t r;
          r = exp_r.pop_front();
          check("pass", {63'h0, PASS}, {63'h0, r.pass});
          check("bus_err", {63'h0, BUS_ERR}, {63'h0, r.be});
          check("err_cnt", {48'h0, ERR_CNT}, {48'h0, r.ec});
          check("fail_addr", {32'h0, FAIL_ADDR}, {32'h0, r.fa});
          check("busy_in_done", {63'h0, BUSY}, 64'h0);
          check("run_cycles", 64'(cyc - busy_cyc + 1), 64'(r.cyc));
        end
      end
      prev_done = DONE;
      prev_busy = BUSY;
    end else begin
      prev_done = 1'b0;
      prev_busy = 1'b0;
    end
  end

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 2000) begin tick(); n++; end
    if (done_seen < target) check("done_timeout", 64'(done_seen), 64'(target));
  endtask

  task automatic pulse_start();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"}, {62'h0, HTRANS}, 64'h0);
    check({tag, "_haddr"}, {32'h0, HADDR}, 64'h0);
    check({tag, "_hwrite"}, {63'h0, HWRITE}, 64'h0);
    check({tag, "_hwdata"}, HWDATA, 64'h0);
    check({tag, "_flags"}, {60'h0, BUSY, DONE, PASS, BUS_ERR}, 64'h0);
    check({tag, "_err_cnt"}, {48'h0, ERR_CNT}, 64'h0);
    check({tag, "_fail_addr"}, {32'h0, FAIL_ADDR}, 64'h0);
  endtask

  initial begin
    int n;
    HRESETN = 1'b0;
    START   = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    check("hsize", {61'h0, HSIZE}, 64'h3);
    check("hburst", {61'h0, HBURST}, 64'h0);
    HRESETN = 1'b1;
    tick();

    // Zero-wait full run.
    ws = 0;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b1, 1'b0, 16'd0, 32'h0, 17);
    pulse_start(); wait_done(1);
    check("xfer_q_empty_1", 64'(exp_x.size()), 64'h0);
    tick(); tick();
    check("done_held", {62'h0, DONE, PASS}, 64'h3);

    // Three wait states on every phase.
    ws = 3;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b1, 1'b0, 16'd0, 32'h0, 65);
    pulse_start(); wait_done(2);
    check("xfer_q_empty_2", 64'(exp_x.size()), 64'h0);

    // Word 2 corrupted on read.
    ws = 0; bad_en = 1'b1; bad_addr = 32'h10;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b0, 1'b0, 16'd1, 32'h10, 17);
    pulse_start(); wait_done(3);
    bad_en = 1'b0;
    check("xfer_q_empty_3", 64'(exp_x.size()), 64'h0);

    // Bus error on write of word 1, error held during wait states too.
    ws = 3; err_en = 1'b1; err_addr = 32'h08;
    push_xfers(1'b1, 2);
    push_res(1'b0, 1'b1, 16'd0, 32'h0, 17);
    pulse_start(); wait_done(4);
    tick(); tick(); tick();
    err_en = 1'b0;
    check("xfer_q_empty_4", 64'(exp_x.size()), 64'h0);

    // Reset during the data phase of read word 1.
    ws = 3;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    pulse_start();
    n = 0;
    while (!(dphase && !dwrite && daddr == 32'h08) && n < 500) begin tick(); n++; end
    check("reached_rd_d1", {63'h0, dphase && !dwrite && daddr == 32'h08}, 64'h1);
    HRESETN = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_x.delete();
    tick();
    HRESETN = 1'b1;
    tick();
    check("post_reset_idle", {61'h0, HTRANS, BUSY}, 64'h0);
    ws = 0;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b1, 1'b0, 16'd0, 32'h0, 17);
    pulse_start(); wait_done(5);
    check("xfer_q_empty_5", 64'(exp_x.size()), 64'h0);

    // START held: ignored during run, back-to-back rerun with cleared results.
    bad_en = 1'b1; bad_addr = 32'h10;
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b0, 1'b0, 16'd1, 32'h10, 17);
    push_xfers(1'b1, NW); push_xfers(1'b0, NW);
    push_res(1'b1, 1'b0, 16'd0, 32'h0, 17);
    START = 1'b1;
    wait_done(6);
    bad_en = 1'b0;
    tick();
    check("rerun_busy", {62'h0, BUSY, DONE}, 64'h2);
    START = 1'b0;
    wait_done(7);
    check("xfer_q_empty_6", 64'(exp_x.size()), 64'h0);
    check("res_q_empty", 64'(exp_r.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
